// File: rtl/nibble_swap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nibble_swap_arbiter
// Description : Round-robin arbiter sharing one registered nibble-swap
//               datapath among NUM_REQ byte requesters. The winning byte is
//               nibble-swapped (or passed through) into a single-entry output
//               register tagged with the requester id, with valid/ready
//               backpressure on the output side.
//               Optional feature macro: SWAP_ARB_STATS_EN adds per-requester
//               16-bit saturating grant counters with a select/clear read port.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_swap_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_swap,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready
`ifdef SWAP_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]      cnt_sel,
  input  logic                 cnt_clr,
  output logic [15:0]          cnt_val
`endif
);

  // Output register occupancy: EMPTY means out_valid low, FULL means a
  // result is waiting for the consumer.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              can_accept;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              grant_any;
  logic [7:0]        win_byte;
  logic              win_swap;
  logic [31:0]       scan_idx;

  // A new result may enter when the register is empty or is being drained
  // in this same cycle.
  assign can_accept = (state_q == EMPTY) || out_ready;

  // Rotating priority search: start at rr_ptr and walk upward modulo NUM_REQ,
  // the first active request wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = 32'(rr_ptr_q) + 32'(i);
      if (scan_idx >= 32'(NUM_REQ)) begin
        scan_idx = scan_idx - 32'(NUM_REQ);
      end
      if (!found && req[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  // A grant only happens when there is room; reset forces it off so nothing
  // is advertised to the requesters while the block is being cleared.
  assign grant_any = found && can_accept && !reset;

  // One-hot grant vector decoded from the winning index.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = grant_any && (32'(winner) == 32'(i));
    end
  end

  // Winner's byte and swap flag, then the nibble exchange itself.
  assign win_byte = req_data[{winner, 3'b000} +: 8];
  assign win_swap = req_swap[winner];

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    if (grant_any) begin
      state_d = FULL;
      data_d  = win_swap ? {win_byte[3:0], win_byte[7:4]} : win_byte;
      id_d    = winner;
      if (32'(winner) == 32'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner + 1'b1;
      end
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State, pointer and output register; reset discards any held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      data_q   <= 8'h00;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef SWAP_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Per-requester saturating grant counters; a clear wins over an increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = 16'h0000;
      end else if (gnt[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'h0001;
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Combinational read of the selected counter; unused select codes read 0.
  always_comb begin
    cnt_val = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (32'(cnt_sel) == 32'(i)) begin
        cnt_val = cnt_q[i];
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_swap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_swap_arbiter
// Description : Directed self-checking bench for nibble_swap_arbiter.
//               Inputs are driven on the falling edge, outputs checked there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_swap_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_swap = '0;
  logic [NUM_REQ-1:0]   gnt;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready = 1'b0;
`ifdef SWAP_ARB_STATS_EN
  logic [ID_W-1:0]      cnt_sel = '0;
  logic                 cnt_clr = 1'b0;
  logic [15:0]          cnt_val;
`endif

  int checks = 0;
  int errors = 0;

  // Expected transformed byte per requester for the fixed input bytes below:
  // r0 8'h12 pass, r1 8'h3C pass, r2 8'hA5 swap, r3 8'hC7 swap.
  logic [7:0] exp_tab [NUM_REQ];

  nibble_swap_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_swap  (req_swap),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef SWAP_ARB_STATS_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_clr   (cnt_clr),
    .cnt_val   (cnt_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_tab[0] = 8'h12;
    exp_tab[1] = 8'h3C;
    exp_tab[2] = 8'h5A;
    exp_tab[3] = 8'h7C;
    req_data = {8'hC7, 8'hA5, 8'h3C, 8'h12};
    req_swap = 4'b1100;

    // Reset held with everybody requesting: grant must stay off.
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk("gnt_in_reset", 16'(gnt), 16'h0);
    chk("valid_in_reset", 16'(out_valid), 16'h0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_data", 16'(out_data), 16'h00);
    chk("rst_id", 16'(out_id), 16'h0);

    // Single request from requester 2 with swap.
    req = 4'b0100;
    #1;
    chk("single_gnt", 16'(gnt), 16'h4);
    @(negedge clk);
    chk("single_valid", 16'(out_valid), 16'h1);
    chk("single_data", 16'(out_data), 16'h5A);
    chk("single_id", 16'(out_id), 16'h2);

    // Backpressure: everyone requesting, consumer stalled for 5 cycles.
    req = 4'b1111;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_gnt", 16'(gnt), 16'h0);
      chk("bp_data", 16'(out_data), 16'h5A);
      chk("bp_valid", 16'(out_valid), 16'h1);
      @(negedge clk);
    end
    // Drain and refill in the same cycle; pointer sits at 3 after winner 2.
    out_ready = 1'b1;
    #1;
    chk("refill_gnt", 16'(gnt), 16'h8);
    @(negedge clk);
    chk("refill_data", 16'(out_data), 16'h7C);
    chk("refill_id", 16'(out_id), 16'h3);

    // Continuous round robin with wrap-around: 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt", 16'(gnt), 16'(4'b0001 << (k % 4)));
      @(negedge clk);
      chk("rr_valid", 16'(out_valid), 16'h1);
      chk("rr_id", 16'(out_id), 16'(k % 4));
      chk("rr_data", 16'(out_data), 16'(exp_tab[k % 4]));
    end

    // No requests: drain to EMPTY, data and id hold, ready while empty ignored.
    req = '0;
    #1;
    chk("idle_gnt", 16'(gnt), 16'h0);
    @(negedge clk);
    chk("drain_valid", 16'(out_valid), 16'h0);
    chk("drain_data", 16'(out_data), 16'h7C);
    chk("drain_id", 16'(out_id), 16'h3);
    @(negedge clk);
    chk("empty_ready_valid", 16'(out_valid), 16'h0);

    // Pointer stayed at 0 while idle: 1 beats 3.
    req = 4'b1010;
    #1;
    chk("ptr_hold_gnt", 16'(gnt), 16'h2);
    @(negedge clk);
    chk("pass_data", 16'(out_data), 16'h3C);
    chk("pass_id", 16'(out_id), 16'h1);

    // Stall while FULL, then reset asynchronously between edges.
    req = 4'b1111;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 16'(out_valid), 16'h0);
    chk("async_gnt", 16'(gnt), 16'h0);
    chk("async_data", 16'(out_data), 16'h00);
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0110;
    out_ready = 1'b1;
    #1;
    chk("post_rst_gnt", 16'(gnt), 16'h2);
    @(negedge clk);
    chk("post_rst_id", 16'(out_id), 16'h1);
    chk("post_rst_data", 16'(out_data), 16'h3C);

`ifdef SWAP_ARB_STATS_EN
    // Three grants to requester 3 (only requester active).
    req = 4'b1000;
    cnt_sel = 2'd3;
    repeat (3) @(negedge clk);
    #1;
    chk("cnt3", cnt_val, 16'd3);
    // Clear in the same cycle as a grant wins.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("cnt_clr", cnt_val, 16'd0);
    // Saturation after more than 65535 grants.
    repeat (65537) @(negedge clk);
    #1;
    chk("cnt_sat", cnt_val, 16'hFFFF);
    @(negedge clk);
    #1;
    chk("cnt_sat_hold", cnt_val, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
